// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester UART transmitter with round-robin arbitration.
// A byte accepted from either requester is serialised LSB first as an 8N1 frame.
// The frame is start, eight data bits and stop, with every bit lasting
// CLKS_PER_BIT enabled cycles.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    localparam logic [7:0] TIMER_LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] bit_timer;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic [7:0] sel_data;
    logic       last;
    logic       sel;
    logic       any_valid;
    logic       can_accept;
    logic       transfer;
    logic       bit_done;
`ifdef UART_TX_PARITY_EN
    logic       parity_bit;
`endif

    // Round-robin choice: a lone requester wins, a tie goes to whoever did not send last
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    assign any_valid  = req0_valid | req1_valid;
    assign can_accept = rst_n && ena && (state == ST_IDLE);
    assign req0_ready = can_accept && any_valid && !sel;
    assign req1_ready = can_accept && any_valid && sel;
    assign transfer   = req0_ready | req1_ready;
    assign sel_data   = sel ? req1_data : req0_data;
    assign bit_done   = (bit_timer == TIMER_LAST);
    assign shift_next = {1'b0, shift_reg[7:1]};
    assign busy       = (state != ST_IDLE);

    // Frame sequencer: bit timer, data index, shift register, line driver and arbiter history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            bit_timer  <= 8'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            last       <= 1'b1;
            grant_id   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        state      <= ST_START;
                        tx         <= 1'b0;
                        bit_timer  <= 8'd0;
                        bit_idx    <= 3'd0;
                        shift_reg  <= sel_data;
                        last       <= sel;
                        grant_id   <= sel;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^sel_data;
`endif
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        bit_timer <= 8'd0;
                        bit_idx   <= 3'd0;
                        state     <= ST_DATA;
                        tx        <= shift_reg[0];
                    end else begin
                        bit_timer <= bit_timer + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        bit_timer <= 8'd0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= parity_bit;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= shift_next;
                            tx        <= shift_next[0];
                        end
                    end else begin
                        bit_timer <= bit_timer + 8'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        bit_timer <= 8'd0;
                        state     <= ST_STOP;
                        tx        <= 1'b1;
                    end else begin
                        bit_timer <= bit_timer + 8'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        bit_timer <= 8'd0;
                        state     <= ST_IDLE;
                        tx        <= 1'b1;
                    end else begin
                        bit_timer <= bit_timer + 8'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    tx        <= 1'b1;
                    bit_timer <= 8'd0;
                    bit_idx   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter.
// A line monitor decodes every frame from tx and checks it against a queue of
// expected {grant, byte} entries. These entries are pushed when the stimulus
// sees a handshake that the arbitration model predicts.
// Define UART_TX_PARITY_EN to exercise the parity build.
module tb_uart_tx_arbiter;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'd0;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'd0;
    logic       req0_ready;
    logic       req1_ready;
    logic       tx;
    logic       busy;
    logic       grant_id;
    logic [2:0] state;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    logic [8:0]  exp_q[$];
    int          start_q[$];
    logic        model_last = 1'b1;

    logic        mon_active = 1'b0;
    int          mon_n = 0;
    int          mon_k = 0;
    int          mon_start = 0;
    int          last_dur = 0;
    logic [10:0] mon_frame = '1;
    logic [10:0] mon_ef = '1;
    logic [8:0]  mon_exp = '0;

    uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .state      (state)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle stamp used for frame start spacing and duration
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic failNow(input string tag);
        tests_run++;
        tests_failed++;
        $error("[TB] FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [7:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
    endtask

    function automatic logic [10:0] build_frame(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    function automatic logic [2:0] exp_state(input int k);
        if (k == 0) return 3'd1;
        if (k <= 8) return 3'd2;
        if (k == NB - 1) return 3'd3;
        return 3'd4;
    endfunction

    function automatic logic model_sel(input logic v0, input logic v1, input logic lst);
        if (v0 && v1) return ~lst;
        if (v1) return 1'b1;
        return 1'b0;
    endfunction

    // Called at a falling edge; returns at the falling edge just after the handshake edge
    task automatic waitReady(input string tag, output int waited);
        logic got;
        logic s;
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        if (!got) begin
            failNow(tag);
        end else begin
            s = model_sel(req0_valid, req1_valid, model_last);
            checkOutput(tag, {30'd0, req1_ready, req0_ready}, s ? 32'd2 : 32'd1);
            exp_q.push_back({s, s ? req1_data : req0_data});
            model_last = s;
            @(negedge clk);
        end
    endtask

    task automatic waitIdle(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0 && !mon_active) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) failNow(tag);
    endtask

    // Line monitor: decodes frames from tx, counting only enabled clock edges
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_n = 0;
                mon_start = cyc;
                start_q.push_back(cyc);
                mon_frame = '1;
                checkOutput("start_state", 32'(state), 32'd1);
            end
        end else begin
            if (ena) mon_n++;
            if (mon_n == NB * CPB) begin
                checkOutput("end_busy", 32'(busy), 32'd0);
                checkOutput("end_state", 32'(state), 32'd0);
                checkOutput("end_tx", 32'(tx), 32'd1);
                if (exp_q.size() == 0) begin
                    failNow("unexpected_frame");
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_ef = build_frame(mon_exp[7:0]);
                    checkOutput("frame_bits", 32'(mon_frame), 32'(mon_ef));
                    checkOutput("frame_grant", 32'(grant_id), 32'(mon_exp[8]));
                end
                last_dur = cyc - mon_start;
                mon_active = 1'b0;
            end else begin
                checkOutput("frame_busy", 32'(busy), 32'd1);
                if (mon_n % CPB == CPB / 2) begin
                    mon_k = mon_n / CPB;
                    mon_frame[mon_k] = tx;
                    checkOutput("bit_state", 32'(state), 32'(exp_state(mon_k)));
                end
            end
        end
    end

    // Safety net in case a wait is never satisfied
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed no end expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        int          waited;
        int          ready_hits;
        logic [7:0]  frz_byte;

        // Reset state, with both requesters valid to show ready is held low in reset
        applyStimulus(1'b1, 8'h11, 1'b1, 8'h22);
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_grant", 32'(grant_id), 32'd0);
        checkOutput("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

        // Only req1 valid with 0xFF: accepted at once even though last=1
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF);
        waitReady("req1_only", waited);
        checkOutput("req1_only_latency", 32'(waited), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        waitIdle("req1_only_idle");

        // Single byte 0xA5 from req0; ready must not re-pulse while busy
        applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
        waitReady("single_a5", waited);
        ready_hits = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready) ready_hits++;
            @(negedge clk);
        end
        checkOutput("single_ready_once", 32'(ready_hits), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        waitIdle("single_idle");
        checkOutput("single_duration", 32'(last_dur), 32'(NB * CPB));
        checkOutput("single_grant", 32'(grant_id), 32'd0);

        // Back-to-back from reset with both valid: grants alternate, starts 10*CPB+1 apart
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        start_q.delete();
        applyStimulus(1'b1, 8'h11, 1'b1, 8'h22);
        for (int f = 0; f < 4; f++) begin
            waitReady("b2b", waited);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        waitIdle("b2b_idle");
        checkOutput("b2b_frames", 32'(start_q.size()), 32'd4);
        if (start_q.size() == 4) begin
            for (int f = 0; f < 3; f++) begin
                checkOutput("b2b_spacing", 32'(start_q[f + 1] - start_q[f]), 32'(NB * CPB + 1));
            end
        end

        // ena low for 7 cycles in the middle of data bit 3
        frz_byte = 8'h96;
        applyStimulus(1'b0, 8'h00, 1'b1, frz_byte);
        waitReady("freeze", waited);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (4 * CPB + 1) @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("freeze_tx", 32'(tx), 32'(frz_byte[3]));
            checkOutput("freeze_state", 32'(state), 32'd2);
        end
        ena = 1'b1;
        waitIdle("freeze_idle");
        checkOutput("freeze_duration", 32'(last_dur), 32'(NB * CPB + 7));

        // ena low in IDLE blocks the handshake; then bytes 0x07 and 0x03 (parity 1 and 0)
        ena = 1'b0;
        applyStimulus(1'b1, 8'h07, 1'b0, 8'h00);
        #1;
        checkOutput("ena_low_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        checkOutput("ena_low_state", 32'(state), 32'd0);
        ena = 1'b1;
        waitReady("byte_07", waited);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        waitIdle("byte_07_idle");
        checkOutput("byte_07_duration", 32'(last_dur), 32'(NB * CPB));
        applyStimulus(1'b1, 8'h03, 1'b0, 8'h00);
        waitReady("byte_03", waited);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        waitIdle("byte_03_idle");
        checkOutput("byte_03_duration", 32'(last_dur), 32'(NB * CPB));

        // Reset in the middle of DATA drops the byte and the round-robin history
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C);
        waitReady("midrst", waited);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (2 * CPB + 2) @(negedge clk);
        applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
        #1;
        checkOutput("busy_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_tx", 32'(tx), 32'd1);
        checkOutput("midrst_state", 32'(state), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_grant", 32'(grant_id), 32'd0);
        exp_q.delete();
        model_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b1, 8'hC3);
        waitReady("post_rst", waited);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        waitIdle("post_rst_idle");
        checkOutput("post_rst_grant", 32'(grant_id), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
